// File: rtl/ssd_bcd_writer.sv
// ---------------------------------------------------------------------------
// ssd_bcd_writer
//
// Takes an unsigned binary result and converts it to four BCD digits with a
// sequential double-dabble converter, one iteration per clock. It then writes
// the digits into the four-digit seven-segment display, one digit per cycle,
// over the display's num/sel/wr write port. Inputs above MAX_VAL are clamped
// to MAX_VAL and flagged on ovf.
//
// Ports
//   clk    : system clock, all logic on the rising edge
//   reset  : synchronous, active-high reset
//   start  : request to display 'value'; only looked at while idle
//   value  : unsigned binary value, captured on the accepting edge
//   busy   : high while a request is in progress
//   done   : one-cycle pulse after the fourth digit has been written
//   ovf    : last accepted value was above MAX_VAL; held until next accept
//   num    : BCD digit for the display write port
//   sel    : digit select, 0 = thousands (leftmost) .. 3 = units (rightmost)
//   wr     : display write enable
//
// State table
//   S_IDLE    | waiting for start; captures (clamped) value on accept
//   S_CONVERT | DATA_W double-dabble iterations, one per cycle
//   S_WRITE   | four digit writes, thousands first
//   S_DONE    | single cycle that raises done, then back to idle
//
// Every output comes straight from a flop. busy/done/wr are registered from
// the state held in the previous cycle, so they follow state_q by one edge.
// That lag is why busy is still high in the cycle that follows DONE.
// ---------------------------------------------------------------------------
module ssd_bcd_writer #(
    parameter int DATA_W  = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [3:0]        num,
    output logic [1:0]        sel,
    output logic              wr
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam int CNT_W = 5;

    // The clamp constant is trimmed to the input width. For narrow DATA_W the
    // input can never exceed MAX_VAL, so the truncated value is never used.
    localparam logic [DATA_W-1:0] MAX_W      = DATA_W'(MAX_VAL);
    localparam logic [31:0]       MAX_32     = 32'(MAX_VAL);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [15:0]       bcd_q,   bcd_d;
    logic [1:0]        idx_q,   idx_d;

    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              ovf_q,   ovf_d;
    logic [3:0]        num_q,   num_d;
    logic [1:0]        sel_q,   sel_d;
    logic              wr_q,    wr_d;

    logic [15:0]       bcd_adj;
    logic [3:0]        digit_sel;

    // Double-dabble correction: any nibble that is 5 or more would overflow
    // past 9 after the doubling shift, so it is pre-biased by 3.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int n = 0; n < 4; n++) begin
            if (r[4*n +: 4] >= 4'd5) begin
                r[4*n +: 4] = r[4*n +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_adj = dabble_adjust(bcd_q);

    // Digit index 0 addresses the thousands nibble (the top of the BCD word).
    always_comb begin
        digit_sel = bcd_q[15:12];
        case (idx_q)
            2'd0: digit_sel = bcd_q[15:12];
            2'd1: digit_sel = bcd_q[11:8];
            2'd2: digit_sel = bcd_q[7:4];
            2'd3: digit_sel = bcd_q[3:0];
            default: digit_sel = bcd_q[15:12];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        num_d   = num_q;
        sel_d   = sel_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (32'(value) > MAX_32) begin
                        shift_d = MAX_W;
                        ovf_d   = 1'b1;
                    end else begin
                        shift_d = value;
                        ovf_d   = 1'b0;
                    end
                    bcd_d   = 16'd0;
                    cnt_d   = CNT_LOAD;
                    state_d = S_CONVERT;
                end
            end

            S_CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj[14:0], shift_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    idx_d   = 2'd0;
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                wr_d  = 1'b1;
                sel_d = idx_q;
                num_d = digit_sel;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            num_q   <= 4'd0;
            sel_q   <= 2'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            num_q   <= num_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign num  = num_q;
    assign sel  = sel_q;
    assign wr   = wr_q;

endmodule

// File: tb/tb_ssd_bcd_writer.sv
// ---------------------------------------------------------------------------
// tb_ssd_bcd_writer
//
// Directed and random transactions against ssd_bcd_writer. For each accepted
// value the bench works out the clamped value and its four decimal digits
// with plain division. It then checks every output on every cycle from the
// accepting edge (t = 0) through the cycle after done (t = DATA_W + 6).
// Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ssd_bcd_writer;

    localparam int DATA_W  = 14;
    localparam int MAX_VAL = 9999;
    localparam int W_FIRST = DATA_W + 1;   // first write, edges after accept
    localparam int W_LAST  = DATA_W + 4;
    localparam int DONE_T  = DATA_W + 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] value;
    logic              busy, done, ovf, wr;
    logic [3:0]        num;
    logic [1:0]        sel;

    int n_checks = 0;
    int n_errors = 0;

    // Last digit/select driven onto the write port (held outside writes).
    logic [3:0] held_num;
    logic [1:0] held_sel;

    ssd_bcd_writer #(.DATA_W(DATA_W), .MAX_VAL(MAX_VAL)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .num   (num),
        .sel   (sel),
        .wr    (wr)
    );

    always #10 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input int v);
        @(negedge clk);
        value = DATA_W'(v);
        start = 1'b1;
    endtask

    // Caller has start=1 and value=v set up for the next rising edge.
    // hold=1 keeps start high all the way through (and leaves it high).
    task automatic run_txn(input int v, input bit hold, input int stop_at);
        int  clamped;
        bit  exp_ovf;
        int  dig[4];
        bit  exp_wr;
        clamped = (v > MAX_VAL) ? MAX_VAL : v;
        exp_ovf = (v > MAX_VAL);
        dig[0]  = clamped / 1000;
        dig[1]  = (clamped / 100) % 10;
        dig[2]  = (clamped / 10) % 10;
        dig[3]  = clamped % 10;

        @(posedge clk);
        #1;
        for (int t = 0; t <= stop_at; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            exp_wr = (t >= W_FIRST) && (t <= W_LAST);
            if (exp_wr) begin
                held_sel = 2'(t - W_FIRST);
                held_num = 4'(dig[t - W_FIRST]);
            end
            check($sformatf("busy v=%0d t=%0d", v, t), 32'(busy), 32'((t >= 1) && (t <= DONE_T)));
            check($sformatf("wr v=%0d t=%0d", v, t), 32'(wr), 32'(exp_wr));
            check($sformatf("done v=%0d t=%0d", v, t), 32'(done), 32'(t == DONE_T));
            check($sformatf("sel v=%0d t=%0d", v, t), 32'(sel), 32'(held_sel));
            check($sformatf("num v=%0d t=%0d", v, t), 32'(num), 32'(held_num));
            if (t >= 1) begin
                check($sformatf("ovf v=%0d t=%0d", v, t), 32'(ovf), 32'(exp_ovf));
            end

            // Inputs for the next edge: value keeps changing, and start is
            // pulsed at random, which must be ignored while busy or in DONE.
            value = DATA_W'($urandom);
            if (hold) begin
                start = 1'b1;
            end else if (t < DONE_T) begin
                start = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        int v;
        int v2;
        int dir_vals[9];

        dir_vals = '{1234, 0, 9999, 12000, 42, 5678, 16383, 10000, 9998};

        reset    = 1'b1;
        start    = 1'b0;
        value    = '0;
        held_num = 4'd0;
        held_sel = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst ovf",  32'(ovf),  32'd0);
        check("rst num",  32'(num),  32'd0);
        check("rst sel",  32'(sel),  32'd0);
        check("rst wr",   32'(wr),   32'd0);
        reset = 1'b0;

        foreach (dir_vals[i]) begin
            start_txn(dir_vals[i]);
            run_txn(dir_vals[i], 1'b0, DONE_T + 1);
        end

        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(0, (1 << DATA_W) - 1));
            start_txn(v);
            run_txn(v, 1'b0, DONE_T + 1);
        end

        // start held high: the second acceptance happens on the edge right
        // after done, using whatever value is present on that edge.
        v = int'($urandom_range(0, (1 << DATA_W) - 1));
        start_txn(v);
        run_txn(v, 1'b1, DONE_T);
        v2 = int'($urandom_range(0, (1 << DATA_W) - 1));
        value = DATA_W'(v2);
        run_txn(v2, 1'b0, DONE_T + 1);

        // Reset after the first two writes have gone out.
        v = 3456;
        start_txn(v);
        run_txn(v, 1'b0, W_FIRST + 1);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        held_num = 4'd0;
        held_sel = 2'd0;
        check("midrst wr",   32'(wr),   32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst ovf",  32'(ovf),  32'd0);
        check("midrst sel",  32'(sel),  32'd0);
        check("midrst num",  32'(num),  32'd0);
        reset = 1'b0;
        for (int c = 0; c < DONE_T + 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-rst done c=%0d", c), 32'(done), 32'd0);
            check($sformatf("post-rst wr c=%0d", c),   32'(wr),   32'd0);
            check($sformatf("post-rst busy c=%0d", c), 32'(busy), 32'd0);
        end

        v = 7890;
        start_txn(v);
        run_txn(v, 1'b0, DONE_T + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ssd_bcd_writer.md
Name: ssd_bcd_writer

Overview:
Upstream feeder for the four-digit seven-segment display block. It takes a binary result from the RISC-V datapath, converts it to four BCD digits with a sequential double-dabble converter, and writes those digits into the display's digit registers. The writes go out one per cycle on the display's num/sel/wr write port. The block owns the write port exclusively; the display scans normally whenever wr is low.

Parameters:
DATA_W, 14, width of the binary input value; legal range 4..16.
MAX_VAL, 9999, largest displayable value; larger inputs are clamped to this.

Ports:
clk  input  1  system clock (50 MHz), all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request to display value; sampled only in IDLE
value  input  DATA_W  unsigned binary value to display
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when all four digits have been written
ovf  output  1  value exceeded MAX_VAL on the last accepted start; held until next accepted start
num  output  4  BCD digit to the display write port
sel  output  2  digit select; 00 = leftmost (thousands), 11 = rightmost (units)
wr  output  1  display write enable

Behaviour:
- Reset state: state=IDLE; busy=0, done=0, ovf=0, num=0, sel=00, wr=0; BCD and shift registers cleared.
- Reset mid-operation: the state returns to IDLE at the next edge. wr=0 from that edge on. Digits already written stay in the display; no further writes are issued.
- All outputs are registered.
- FSM states: IDLE, CONVERT, WRITE, DONE.
- IDLE:
  - start=1 at edge k accepts the request.
  - If value > MAX_VAL, load MAX_VAL and set ovf=1; otherwise load value and set ovf=0.
  - Clear the 16-bit BCD accumulator, set the iteration counter to DATA_W, move to CONVERT.
  - busy=1 from k+1.
- CONVERT, one iteration per cycle (DATA_W cycles, k+1..k+DATA_W):
  - Each BCD nibble >= 5 gets +3.
  - Then {BCD, shift} is shifted left by 1.
  - Decrement the counter; at 0, move to WRITE with digit index 0.
- WRITE, four cycles:
  - Registered outputs wr=1, sel=index, num=BCD nibble (index 0 = thousands, 3 = units).
  - With DATA_W=14, wr is high for cycles k+15..k+18 with sel = 00, 01, 10, 11 in order.
  - After index 3, move to DONE.
- DONE, one cycle (k+19 for DATA_W=14): done=1, wr=0, busy=1. Next state IDLE.
- Total latency from accepting edge to the done pulse: DATA_W+5 cycles.
- start while busy (any non-IDLE state, including DONE) is ignored: no queuing, value not resampled.
- value is sampled only at the accepting edge; later changes have no effect.
- Outside WRITE, wr=0 and num/sel hold their last driven values.
- Every written num is in 0..9.
- Back-to-back: the earliest next acceptance is the cycle after done (IDLE).

Test Plan:
- After reset, value=1234, start pulse at edge k -> busy=1 at k+1; writes (sel,num) = (00,1),(01,2),(10,3),(11,4) on k+15..k+18; done=1 only at k+19; ovf=0; busy=0 at k+20.
- value=0 -> four writes of num=0 with sel 00..11; value=9999 -> four writes of num=9; ovf=0 in both cases.
- value=12000 -> clamped; writes 9,9,9,9; ovf=1 from k+1 and held. A following start with value=42 -> writes 0,0,4,2 and ovf=0.
- start held high continuously with value changing -> only the first value converted per transaction. The next acceptance happens one cycle after done (IDLE), using the value present then.
- reset asserted during WRITE after two writes (sel 00, 01 issued) -> wr=0 from the next edge; busy=0, done never pulses; a new start behaves as from reset.
- Integration with the display block: write 5,6,7,8 -> after done the display scans anodes 0111..1110 showing cathode patterns for 5,6,7,8 in order.
